mem_access_stage: RTL and testbench

MIPS memory-access (MEM) stage with the MEM/WB pipeline register. It takes the EX/MEM results, performs byte/half/word loads and stores against a synchronous data RAM, and registers everything the write-back stage consumes: memory data, ALU data, MemtoReg, RegWrite and the destination register. Its outputs feed the write-back mux directly, with no further registering.

---
 rtl/mem_access_if.sv | 36 +++
 rtl/mem_access_stage.sv | 130 +++++++++++++
 tb/tb_mem_access_stage.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// EX/MEM-side request signals and MEM/WB-side results of the MIPS memory-access stage.
interface mem_access_if #(
  parameter int unsigned B = 32,
  parameter int unsigned D = 5
);
  logic [B-1:0] alu_result;
  logic [B-1:0] write_data;
  logic [D-1:0] write_reg;
  logic         MemRead;
  logic         MemWrite;
  logic         MemtoReg;
  logic         RegWrite;
  logic [1:0]   mem_size;
  logic         mem_unsigned;
  logic         stall;
  logic         flush;

  logic [B-1:0] mem_data;
  logic [B-1:0] ALU_data;
  logic         MemtoReg_out;
  logic         RegWrite_out;
  logic [D-1:0] write_reg_out;
  logic         align_err;

  modport master (
    output alu_result, write_data, write_reg, MemRead, MemWrite, MemtoReg, RegWrite,
           mem_size, mem_unsigned, stall, flush,
    input  mem_data, ALU_data, MemtoReg_out, RegWrite_out, write_reg_out, align_err
  );

  modport slave (
    input  alu_result, write_data, write_reg, MemRead, MemWrite, MemtoReg, RegWrite,
           mem_size, mem_unsigned, stall, flush,
    output mem_data, ALU_data, MemtoReg_out, RegWrite_out, write_reg_out, align_err
  );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: byte/half/word access to a synchronous data RAM plus the MEM/WB register.
// Load data is aligned and extended combinationally from the RAM output register.
module mem_access_stage #(
  parameter int unsigned B = 32,
  parameter int unsigned D = 5,
  parameter int unsigned M = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_access_if.slave  bus
);

  localparam int unsigned NW = 1 << M;

  logic [M-1:0] idx;
  logic [1:0]   off;
  logic         is_half;
  logic         is_word;
  logic         access;
  logic         mis;
  logic         we;
  logic [3:0]   be;
  logic [B-1:0] wd;

  assign idx     = bus.alu_result[M+1:2];
  assign off     = bus.alu_result[1:0];
  assign is_half = (bus.mem_size == 2'b01);
  assign is_word = bus.mem_size[1];
  assign access  = bus.MemRead | bus.MemWrite;
  assign mis     = access & ((is_half & off[0]) | (is_word & (off != 2'b00)));
  assign we      = bus.MemWrite & ~mis & ~bus.flush & ~bus.stall;

  // Byte enables and lane-replicated store data
  always_comb begin
    be = 4'b1111;
    wd = bus.write_data;
    case (bus.mem_size)
      2'b00: begin
        be = 4'b0001 << off;
        wd = {4{bus.write_data[7:0]}};
      end
      2'b01: begin
        be = off[1] ? 4'b1100 : 4'b0011;
        wd = {2{bus.write_data[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  logic [B-1:0] ram [NW];
  logic [B-1:0] rdata_q;

  // Data RAM is not reset; its read register holds while stalled
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) ram[idx][8*k +: 8] <= wd[8*k +: 8];
      end
    end
    if (!bus.stall) rdata_q <= ram[idx];
  end

  logic [B-1:0] alu_q;
  logic [D-1:0] wr_q;
  logic         m2r_q;
  logic         rw_q;
  logic         err_q;
  logic         rd_q;
  logic [1:0]   off_q;
  logic [1:0]   size_q;
  logic         uns_q;

  // MEM/WB register: flush loads a bubble, stall holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q  <= '0;
      wr_q   <= '0;
      m2r_q  <= 1'b0;
      rw_q   <= 1'b0;
      err_q  <= 1'b0;
      rd_q   <= 1'b0;
      off_q  <= 2'b00;
      size_q <= 2'b00;
      uns_q  <= 1'b0;
    end else if (bus.flush) begin
      alu_q  <= '0;
      wr_q   <= '0;
      m2r_q  <= 1'b0;
      rw_q   <= 1'b0;
      err_q  <= 1'b0;
      rd_q   <= 1'b0;
      off_q  <= 2'b00;
      size_q <= 2'b00;
      uns_q  <= 1'b0;
    end else if (!bus.stall) begin
      alu_q  <= bus.alu_result;
      wr_q   <= bus.write_reg;
      m2r_q  <= bus.MemtoReg;
      rw_q   <= bus.RegWrite & ~mis;
      err_q  <= mis;
      rd_q   <= bus.MemRead & ~bus.MemWrite & ~mis;
      off_q  <= off;
      size_q <= bus.mem_size;
      uns_q  <= bus.mem_unsigned;
    end
  end

  logic [7:0]   b8;
  logic [15:0]  h16;
  logic [B-1:0] ld;

  // Lane select and sign/zero extension of the registered read word
  always_comb begin
    b8  = rdata_q[{off_q, 3'b000} +: 8];
    h16 = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (size_q)
      2'b00:   ld = uns_q ? {{(B-8){1'b0}}, b8}   : {{(B-8){b8[7]}}, b8};
      2'b01:   ld = uns_q ? {{(B-16){1'b0}}, h16} : {{(B-16){h16[15]}}, h16};
      default: ld = rdata_q;
    endcase
  end

  assign bus.mem_data      = rd_q ? ld : '0;
  assign bus.ALU_data      = alu_q;
  assign bus.MemtoReg_out  = m2r_q;
  assign bus.RegWrite_out  = rw_q;
  assign bus.write_reg_out = wr_q;
  assign bus.align_err     = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage against a byte-addressed memory model.
module tb_mem_access_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_if #(.B(32), .D(5)) bus ();
  mem_access_stage #(.B(32), .D(5), .M(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic [7:0]  mb [1024];
  logic [71:0] expv;

  function automatic logic [71:0] obs();
    return {bus.mem_data, bus.ALU_data, bus.MemtoReg_out, bus.RegWrite_out,
            bus.write_reg_out, bus.align_err};
  endfunction

  task automatic idle();
    bus.alu_result = '0; bus.write_data = '0; bus.write_reg = '0;
    bus.MemRead = 0; bus.MemWrite = 0; bus.MemtoReg = 0; bus.RegWrite = 0;
    bus.mem_size = 2'b10; bus.mem_unsigned = 0; bus.stall = 0; bus.flush = 0;
  endtask

  // Apply one instruction for one cycle and advance the reference model
  task automatic drive(input logic [31:0] a, input logic [31:0] wdat, input logic [4:0] wr,
                       input logic rd, input logic wrt, input logic m2r, input logic rw,
                       input logic [1:0] sz, input logic uns, input logic st, input logic fl);
    int n;
    logic mis;
    logic [31:0] v;
    @(negedge clk);
    bus.alu_result = a; bus.write_data = wdat; bus.write_reg = wr;
    bus.MemRead = rd; bus.MemWrite = wrt; bus.MemtoReg = m2r; bus.RegWrite = rw;
    bus.mem_size = sz; bus.mem_unsigned = uns; bus.stall = st; bus.flush = fl;
    @(posedge clk);
    if (fl) expv = '0;
    else if (!st) begin
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      mis = (rd || wrt) && ((a % n) != 0);
      v = '0;
      if (wrt && !mis)
        for (int i = 0; i < n; i++) mb[10'(a[9:0] + i)] = wdat[8*i +: 8];
      else if (rd && !mis) begin
        for (int i = 0; i < n; i++) v[8*i +: 8] = mb[10'(a[9:0] + i)];
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      end
      expv = {v, a, m2r, rw && !mis, wr, mis};
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    expv = '0;
    repeat (2) @(posedge clk);
    #1;
    if (obs() !== expv) begin errors++; $display("FAIL reset_state: got %h want %h", obs(), expv); end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_preload();
    for (int w = 0; w < 256; w++)
      drive(32'(w * 4), $urandom, 5'd0, 0, 1, 0, 0, 2'b10, 0, 0, 0);
    if (obs() !== expv) begin errors++; $display("FAIL preload: got %h want %h", obs(), expv); end
    checks++;
  endtask

  task automatic test_word();
    drive(32'h10, 32'hDEADBEEF, 5'd0, 0, 1, 0, 0, 2'b10, 0, 0, 0);
    drive(32'h10, 32'h0, 5'd7, 1, 0, 1, 1, 2'b10, 0, 0, 0);
    if (obs() !== expv) begin errors++; $display("FAIL lw_model: got %h want %h", obs(), expv); end
    checks++;
    if ({bus.mem_data, bus.RegWrite_out, bus.write_reg_out} !== {32'hDEADBEEF, 1'b1, 5'd7}) begin
      errors++;
      $display("FAIL lw_deadbeef: got %h/%b/%0d want deadbeef/1/7",
               bus.mem_data, bus.RegWrite_out, bus.write_reg_out);
    end
    checks++;
  endtask

  task automatic test_bytes();
    drive(32'h23, 32'h80, 5'd0, 0, 1, 0, 0, 2'b00, 0, 0, 0);
    drive(32'h20, 32'h0, 5'd3, 1, 0, 1, 1, 2'b10, 0, 0, 0);
    if (bus.mem_data[31:24] !== 8'h80) begin
      errors++; $display("FAIL sb_lane: got %h want 80xxxxxx", bus.mem_data);
    end
    checks++;
    if (obs() !== expv) begin errors++; $display("FAIL sb_word: got %h want %h", obs(), expv); end
    checks++;
    drive(32'h23, 32'h0, 5'd4, 1, 0, 1, 1, 2'b00, 0, 0, 0);
    if (bus.mem_data !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb: got %h want ffffff80", bus.mem_data);
    end
    checks++;
    drive(32'h23, 32'h0, 5'd4, 1, 0, 1, 1, 2'b00, 1, 0, 0);
    if (bus.mem_data !== 32'h00000080) begin
      errors++; $display("FAIL lbu: got %h want 00000080", bus.mem_data);
    end
    checks++;
  endtask

  task automatic test_half();
    drive(32'h22, 32'h5A5A8001, 5'd0, 0, 1, 0, 0, 2'b01, 0, 0, 0);
    drive(32'h22, 32'h0, 5'd5, 1, 0, 1, 1, 2'b01, 0, 0, 0);
    if (bus.mem_data !== 32'hFFFF8001) begin
      errors++; $display("FAIL lh: got %h want ffff8001", bus.mem_data);
    end
    checks++;
    drive(32'h21, 32'h0, 5'd6, 1, 0, 1, 1, 2'b10, 0, 0, 0);
    if ({bus.align_err, bus.RegWrite_out, bus.mem_data} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL lw_misaligned: got err=%b rw=%b data=%h want 1/0/0",
               bus.align_err, bus.RegWrite_out, bus.mem_data);
    end
    checks++;
    drive(32'h21, 32'h12345678, 5'd0, 0, 1, 0, 0, 2'b10, 0, 0, 0);
    drive(32'h20, 32'h0, 5'd6, 1, 0, 1, 1, 2'b10, 0, 0, 0);
    if (bus.mem_data[31:16] !== 16'h8001) begin
      errors++; $display("FAIL sw_misaligned_upper: got %h want 8001xxxx", bus.mem_data);
    end
    checks++;
    if (obs() !== expv) begin errors++; $display("FAIL sw_misaligned: got %h want %h", obs(), expv); end
    checks++;
  endtask

  task automatic test_stall();
    logic [71:0] held;
    drive(32'h30, 32'h0, 5'd9, 1, 0, 1, 1, 2'b10, 0, 0, 0);
    held = obs();
    for (int c = 0; c < 3; c++) begin
      drive(32'h30, 32'hCAFEF00D, 5'd1, 0, 1, 0, 1, 2'b10, 0, 1, 0);
      if (obs() !== expv) begin errors++; $display("FAIL stall_hold%0d: got %h want %h", c, obs(), expv); end
      checks++;
    end
    if (obs() !== held) begin errors++; $display("FAIL stall_frozen: got %h want %h", obs(), held); end
    checks++;
    drive(32'h30, 32'hCAFEF00D, 5'd1, 0, 1, 0, 1, 2'b10, 0, 0, 0);
    drive(32'h30, 32'h0, 5'd2, 1, 0, 1, 1, 2'b10, 0, 0, 0);
    if (bus.mem_data !== 32'hCAFEF00D) begin
      errors++; $display("FAIL stall_commit: got %h want cafef00d", bus.mem_data);
    end
    checks++;
    // A store abandoned while stalled must leave RAM untouched
    drive(32'h34, 32'h11112222, 5'd0, 0, 1, 0, 0, 2'b10, 0, 1, 0);
    drive(32'h34, 32'h11112222, 5'd0, 0, 1, 0, 0, 2'b10, 0, 1, 0);
    drive(32'h34, 32'h0, 5'd0, 0, 0, 0, 0, 2'b10, 0, 0, 0);
    drive(32'h34, 32'h0, 5'd2, 1, 0, 1, 1, 2'b10, 0, 0, 0);
    if (obs() !== expv) begin errors++; $display("FAIL stall_no_write: got %h want %h", obs(), expv); end
    checks++;
  endtask

  task automatic test_flush();
    drive(32'h40, 32'hBADBAD00, 5'd8, 0, 1, 1, 1, 2'b10, 0, 0, 1);
    if (obs() !== 72'h0) begin errors++; $display("FAIL flush_bubble: got %h want 0", obs()); end
    checks++;
    drive(32'h40, 32'h0, 5'd8, 1, 0, 1, 1, 2'b10, 0, 0, 0);
    if (obs() !== expv) begin errors++; $display("FAIL flush_no_write: got %h want %h", obs(), expv); end
    checks++;
    drive(32'h40, 32'h0, 5'd8, 1, 0, 1, 1, 2'b10, 0, 1, 1);
    if (obs() !== 72'h0) begin errors++; $display("FAIL flush_stall_bubble: got %h want 0", obs()); end
    checks++;
  endtask

  task automatic test_reset_mid();
    drive(32'h10, 32'h0, 5'd7, 1, 0, 1, 1, 2'b10, 0, 0, 0);
    bus.stall = 1'b1;
    #2;
    rst_n = 1'b0;
    expv = '0;
    #1;
    if (obs() !== expv) begin errors++; $display("FAIL reset_async: got %h want %h", obs(), expv); end
    checks++;
    @(posedge clk);
    #1;
    if (obs() !== expv) begin errors++; $display("FAIL reset_held: got %h want %h", obs(), expv); end
    checks++;
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    if (bus.RegWrite_out !== 1'b0) begin
      errors++; $display("FAIL reset_release_rw: got %b want 0", bus.RegWrite_out);
    end
    checks++;
    drive(32'h10, 32'h0, 5'd7, 1, 0, 1, 1, 2'b10, 0, 0, 0);
    if (obs() !== expv) begin errors++; $display("FAIL reset_resume: got %h want %h", obs(), expv); end
    checks++;
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  sz;
    int op;
    for (int it = 0; it < 300; it++) begin
      a  = $urandom;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        else if (sz[1]) a[1:0] = 2'b00;
      end
      op = $urandom_range(0, 3);
      drive(a, $urandom, 5'($urandom), op[0], op[1], 1'($urandom), 1'($urandom), sz,
            1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      if (obs() !== expv) begin errors++; $display("FAIL random%0d: got %h want %h", it, obs(), expv); end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_word();
    test_bytes();
    test_half();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
